// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: exception causes, FSM encoding and
// the cause-selection helper.
package pc_pkg;

    typedef enum logic [1:0] {
        PCS_RUN  = 2'd0,
        PCS_TRAP = 2'd1,
        PCS_HALT = 2'd2
    } pcs_state_e;

    localparam logic [1:0] EXC_OPCODE = 2'd0;
    localparam logic [1:0] EXC_OVF    = 2'd1;
    localparam logic [1:0] EXC_DIV0   = 2'd2;
    localparam logic [1:0] EXC_ALIGN  = 2'd3;

    // An explicit request outranks a misaligned target raised in the same cycle.
    function automatic logic [1:0] exc_cause(input logic exc_req, input logic [1:0] exc_code);
        return exc_req ? exc_code : EXC_ALIGN;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/datapath bundle between the control unit, the PC sources and the
// PC sequencer.
interface pc_sequencer_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_SRC = 5,
    parameter int unsigned SEL_W   = 3
);

    logic [NUM_SRC*WIDTH-1:0] src;
    logic [SEL_W-1:0]         pc_source;
    logic                     pc_write;
    logic                     pc_write_cond;
    logic                     zero;
    logic                     exc_req;
    logic [1:0]               exc_code;
    logic                     eret;

    logic [WIDTH-1:0]         pc;
    logic [WIDTH-1:0]         epc;
    logic                     exc_ack;
    logic                     in_handler;
    logic                     halted;
    logic                     sel_err;

    modport master (
        output src, pc_source, pc_write, pc_write_cond, zero, exc_req, exc_code, eret,
        input  pc, epc, exc_ack, in_handler, halted, sel_err
    );

    modport slave (
        input  src, pc_source, pc_write, pc_write_cond, zero, exc_req, exc_code, eret,
        output pc, epc, exc_ack, in_handler, halted, sel_err
    );

endinterface

// File: rtl/pc_src_mux.sv
// NUM_SRC x WIDTH combinational source selector; flags selects with no
// corresponding source and then outputs zero.
module pc_src_mux #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_SRC = 5,
    parameter int unsigned SEL_W   = 3
) (
    input  logic [NUM_SRC*WIDTH-1:0] src,
    input  logic [SEL_W-1:0]         sel,
    output logic [WIDTH-1:0]         tgt,
    output logic                     invalid
);

    always_comb begin
        tgt     = '0;
        invalid = 1'b1;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            if (sel == SEL_W'(k)) begin
                tgt     = src[k*WIDTH +: WIDTH];
                invalid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection, PC/EPC ownership and exception vectoring with
// double-fault halt for the multicycle CPU.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      NUM_SRC      = 5,
    parameter int unsigned      SEL_W        = 3,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_BASE     = WIDTH'(32'h0000_00FC),
    parameter int unsigned      EXC_STRIDE   = 4,
    parameter bit               ALIGN_CHECK  = 1'b1
) (
    input logic         clk,
    input logic         reset,
    pc_sequencer_if.slave bus
);

    pcs_state_e       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             in_handler_q, in_handler_d;
    logic             halted_q, halted_d;
    logic             exc_ack_q, exc_ack_d;
    logic             sel_err_q, sel_err_d;

    logic [WIDTH-1:0] tgt;
    logic             invalid;
    logic             wr;
    logic             mis;
    logic             exc_ev;
    logic [1:0]       cause;
    logic [WIDTH-1:0] vector;

    pc_src_mux #(
        .WIDTH  (WIDTH),
        .NUM_SRC(NUM_SRC),
        .SEL_W  (SEL_W)
    ) u_mux (
        .src    (bus.src),
        .sel    (bus.pc_source),
        .tgt    (tgt),
        .invalid(invalid)
    );

    // An invalid select is reported via sel_err and never raises a misalignment trap.
    assign wr     = bus.pc_write | (bus.pc_write_cond & bus.zero);
    assign mis    = ALIGN_CHECK & wr & ~invalid & (tgt[1:0] != 2'b00);
    assign exc_ev = bus.exc_req | mis;
    assign cause  = exc_cause(bus.exc_req, bus.exc_code);
    assign vector = EXC_BASE + WIDTH'(cause) * WIDTH'(EXC_STRIDE);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        epc_d        = epc_q;
        in_handler_d = in_handler_q;
        halted_d     = halted_q;
        exc_ack_d    = 1'b0;
        sel_err_d    = 1'b0;

        unique case (state_q)
            PCS_HALT: begin
                state_d = PCS_HALT;
            end
            PCS_TRAP: begin
                state_d = PCS_RUN;
            end
            PCS_RUN: begin
                if (exc_ev) begin
                    if (in_handler_q) begin
                        state_d  = PCS_HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d      = PCS_TRAP;
                        epc_d        = pc_q;
                        pc_d         = vector;
                        in_handler_d = 1'b1;
                        exc_ack_d    = 1'b1;
                    end
                end else if (bus.eret && in_handler_q) begin
                    pc_d         = epc_q;
                    in_handler_d = 1'b0;
                end else if (wr && invalid) begin
                    sel_err_d = 1'b1;
                end else if (wr) begin
                    pc_d = tgt;
                end
            end
            default: begin
                state_d = PCS_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= PCS_RUN;
            pc_q         <= RESET_VECTOR;
            epc_q        <= '0;
            in_handler_q <= 1'b0;
            halted_q     <= 1'b0;
            exc_ack_q    <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            in_handler_q <= in_handler_d;
            halted_q     <= halted_d;
            exc_ack_q    <= exc_ack_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.epc        = epc_q;
    assign bus.exc_ack    = exc_ack_q;
    assign bus.in_handler = in_handler_q;
    assign bus.halted     = halted_q;
    assign bus.sel_err    = sel_err_q;

endmodule
